// File: rtl/seq_detector_param.sv
// Serial pattern detector with a loadable target pattern, overlap control,
// a saturating match counter and a registered copy of the match flag.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   x           serial data bit
//   x_valid     x is sampled only while high
//   pattern     new target pattern (bit PAT_W-1 oldest, bit 0 newest)
//   pat_load    loads pattern and restarts detection
//   overlap_en  1 = overlapping matches, 0 = restart after each match
//   count_clr   synchronous clear of match_count
//   z           combinational match flag for the current x
//   z_q         z delayed by one cycle
//   match_count saturating match count
//   fill        number of valid history bits held (0..PAT_W-1)
module seq_detector_param #(
   parameter int                PAT_W     = 4,
   parameter int                CNT_W     = 8,
   parameter logic [PAT_W-1:0]  RESET_PAT = 4'b1011,
   localparam int               FW        = $clog2(PAT_W)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             x_valid,
   input  logic [PAT_W-1:0] pattern,
   input  logic             pat_load,
   input  logic             overlap_en,
   input  logic             count_clr,
   output logic             z,
   output logic             z_q,
   output logic [CNT_W-1:0] match_count,
   output logic [FW-1:0]    fill
);

   localparam logic [FW-1:0]    FULL    = FW'(PAT_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PAT_W-1:0] pat_r;
   logic [PAT_W-2:0] hist;
   logic [PAT_W-1:0] win;

   logic [PAT_W-1:0] pat_n;
   logic [PAT_W-2:0] hist_n;
   logic [FW-1:0]    fill_n;
   logic [CNT_W-1:0] cnt_n;

   // Candidate window: held history plus the bit arriving now.
   assign win = {hist, x};

   // A match needs a full history so stale bits never take part.
   assign z = x_valid & ~pat_load & (fill == FULL) & (win == pat_r);

   always_comb begin
      pat_n  = pat_r;
      hist_n = hist;
      fill_n = fill;
      cnt_n  = match_count;
      if (pat_load) begin
         pat_n  = pattern;
         hist_n = '0;
         fill_n = '0;
         cnt_n  = '0;
      end else begin
         if (x_valid) begin
            hist_n = win[PAT_W-2:0];
            // Non-overlap: discard the matched bits by emptying the window.
            if (z && !overlap_en)
               fill_n = '0;
            else if (fill != FULL)
               fill_n = fill + FW'(1);
         end
         if (count_clr)
            cnt_n = z ? CNT_W'(1) : '0;
         else if (z && match_count != CNT_MAX)
            cnt_n = match_count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_r       <= RESET_PAT;
         hist        <= '0;
         fill        <= '0;
         match_count <= '0;
         z_q         <= 1'b0;
      end else begin
         pat_r       <= pat_n;
         hist        <= hist_n;
         fill        <= fill_n;
         match_count <= cnt_n;
         z_q         <= z;
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic,
// checked against a bit-queue reference model.
module tb_seq_detector_param;

   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          x;
   logic          x_valid;
   logic [PW-1:0] pattern;
   logic          pat_load;
   logic          overlap_en;
   logic          count_clr;
   logic          z, z_q, z2, z_q2;
   logic [7:0]    mc;
   logic [1:0]    mc2;
   logic [1:0]    fill, fill2;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int q[$];
   int m_pat;
   int m_cnt, m_cnt2, m_zq;

   seq_detector_param dut (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
      .pattern(pattern), .pat_load(pat_load),
      .overlap_en(overlap_en), .count_clr(count_clr),
      .z(z), .z_q(z_q), .match_count(mc), .fill(fill)
   );

   seq_detector_param #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
      .pattern(pattern), .pat_load(pat_load),
      .overlap_en(overlap_en), .count_clr(count_clr),
      .z(z2), .z_q(z_q2), .match_count(mc2), .fill(fill2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_z();
      int w;
      if (!x_valid || pat_load || q.size() < PW - 1) return 0;
      w = int'(x);
      for (int i = 0; i < PW - 1; i++)
         w |= q[q.size() - 1 - i] << (i + 1);
      return (w == m_pat) ? 1 : 0;
   endfunction

   task automatic model_reset();
      q.delete();
      m_pat  = 'b1011;
      m_cnt  = 0;
      m_cnt2 = 0;
      m_zq   = 0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".zq"},    int'(z_q),   m_zq);
      chk({tag, ".zq2"},   int'(z_q2),  m_zq);
      chk({tag, ".cnt"},   int'(mc),    m_cnt);
      chk({tag, ".cnt2"},  int'(mc2),   m_cnt2);
      chk({tag, ".fill"},  int'(fill),  q.size());
      chk({tag, ".fill2"}, int'(fill2), q.size());
   endtask

   // One clock of stimulus: z is checked before the edge, registers after.
   task automatic step(input string tag, input logic xi, input logic vi,
                       input logic ld = 0, input logic [PW-1:0] pi = 0,
                       input logic clr = 0);
      int ez;
      @(negedge clk);
      x = xi; x_valid = vi; pat_load = ld; pattern = pi; count_clr = clr;
      #1;
      ez = ref_z();
      chk({tag, ".z"},  int'(z),  ez);
      chk({tag, ".z2"}, int'(z2), ez);
      @(posedge clk);
      #1;
      if (ld) begin
         m_pat = int'(pi);
         q.delete();
         m_cnt = 0;
         m_cnt2 = 0;
      end else begin
         if (clr) begin
            m_cnt = ez; m_cnt2 = ez;
         end else if (ez == 1) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         if (vi) begin
            q.push_back(int'(xi));
            if (ez == 1 && !overlap_en) q.delete();
            while (q.size() > PW - 1) void'(q.pop_front());
         end
      end
      m_zq = ez;
      check_regs(tag);
   endtask

   task automatic stream(input string tag, input logic [31:0] bits,
                         input int n);
      for (int i = n - 1; i >= 0; i--) step(tag, bits[i], 1'b1);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #2;
      x_valid = 1'b1; x = 1'b1; pat_load = 0; count_clr = 0;
      reset = 1'b1;
      #1;
      model_reset();
      chk({tag, ".z"}, int'(z), 0);
      check_regs(tag);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      x_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; x = 0; x_valid = 0; pattern = '0;
      pat_load = 0; overlap_en = 0; count_clr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.z", int'(z), 0);
      check_regs("rst");
      @(negedge clk);
      reset = 1'b0;

      // first match of 1011, only on the 4th bit
      stream("basic", 32'b1011, 4);
      chk("basic.cnt1", int'(mc), 1);

      do_reset("r1");
      overlap_en = 1'b1;
      stream("ovl", 32'b1011011, 7);
      chk("ovl.cnt2", int'(mc), 2);

      overlap_en = 1'b0;
      step("reload", 0, 1, 1, 4'b1011);
      stream("novl", 32'b1011011, 7);
      chk("novl.cnt1", int'(mc), 1);

      step("reload2", 0, 0, 1, 4'b1011);
      step("gap", 1, 1);
      step("gap", 0, 0); step("gap", 1, 0);
      step("gap", 0, 1);
      step("gap", 1, 0);
      step("gap", 1, 1);
      step("gap", 0, 0); step("gap", 0, 0);
      step("gap", 1, 1);
      chk("gap.cnt1", int'(mc), 1);

      stream("pl", 32'b101, 3);
      step("pl.load", 1, 1, 1, 4'b0110);
      chk("pl.fill0", int'(fill), 0);
      chk("pl.cnt0", int'(mc), 0);
      stream("pl.a", 32'b110, 3);
      stream("pl.b", 32'b0110, 4);
      chk("pl.cnt1", int'(mc), 1);

      step("sat.load", 0, 0, 1, 4'b1011);
      overlap_en = 1'b1;
      stream("sat", 32'b1011011011011011, 16);
      chk("sat.cnt2", int'(mc2), 3);
      chk("sat.cnt", int'(mc), 5);
      step("clr", 0, 0, 0, 0, 1);
      chk("clr.cnt", int'(mc), 0);
      stream("mid", 32'b101, 3);
      do_reset("r2");
      stream("post", 32'b011, 3);
      stream("post2", 32'b1011, 4);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0)
            overlap_en = $urandom_range(0, 1);
         step("rnd", $urandom_range(0, 1),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 99) == 0,
              ($urandom_range(0, 1) == 0) ? 4'b1011 : PW'($urandom),
              $urandom_range(0, 39) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
